// File: rtl/ft60x_mode245_bridge.sv
// ---------------------------------------------------------------------------
// ft60x_mode245_bridge
//
// Purpose:
//   Bridges the FTDI FT600/FT601 245-synchronous FIFO bus to a pair of local
//   show-ahead FIFOs. Words the chip offers (RXF# low) are read into the RX
//   FIFO. Words pushed into the TX FIFO are written to the chip while it
//   accepts them (TXE# low). The bidirectional pads are split into in/out/oe
//   signals. All chip-facing outputs are registered, and a one-cycle TURN
//   state separates every burst so that the bridge and the chip never drive
//   the bus together.
//
// Optional feature (macro FT_BURST_LIMIT_EN):
//   When defined, a burst ends after MAX_BURST words. The next IDLE decision
//   then favours the opposite direction if that direction is ready. When it
//   is undefined, bursts are unbounded and RX always wins arbitration.
//
// Ports:
//   clk, rst        FT chip clock; synchronous active-high reset
//   tx_en/tx_in     push a word into the TX FIFO (ignored when full)
//   tx_full         TX FIFO full
//   rx_en           pop the RX FIFO head (ignored when empty)
//   rx_out/rx_be    RX FIFO head word and its byte enables (show-ahead)
//   rx_empty        RX FIFO empty
//   ft_data_*       FT data pads, in/out halves
//   ft_be_*         FT byte-enable pads, in/out halves
//   ft_bus_oe       high while the bridge drives ft_data/ft_be pads
//   ft_txe, ft_rxf  chip status, active-low
//   ft_oe, ft_rd, ft_wr  chip strobes, active-low, registered
// ---------------------------------------------------------------------------
`default_nettype none

module ft60x_mode245_bridge #(
    parameter int DATA_WIDTH   = 16,
    parameter int RX_BUF_WIDTH = 4,
    parameter int TX_BUF_WIDTH = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_en,
    input  logic [DATA_WIDTH-1:0]   tx_in,
    output logic                    tx_full,
    input  logic                    rx_en,
    output logic [DATA_WIDTH-1:0]   rx_out,
    output logic [DATA_WIDTH/8-1:0] rx_be,
    output logic                    rx_empty,
    input  logic [DATA_WIDTH-1:0]   ft_data_in,
    output logic [DATA_WIDTH-1:0]   ft_data_out,
    input  logic [DATA_WIDTH/8-1:0] ft_be_in,
    output logic [DATA_WIDTH/8-1:0] ft_be_out,
    output logic                    ft_bus_oe,
    input  logic                    ft_txe,
    input  logic                    ft_rxf,
    output logic                    ft_oe,
    output logic                    ft_rd,
    output logic                    ft_wr
);

    localparam int BE_W     = DATA_WIDTH / 8;
    localparam int RX_W     = DATA_WIDTH + BE_W;
    localparam int RX_DEPTH = 1 << RX_BUF_WIDTH;
    localparam int TX_DEPTH = 1 << TX_BUF_WIDTH;

    localparam logic [RX_BUF_WIDTH:0] RX_ONE_FREE = (RX_BUF_WIDTH+1)'(RX_DEPTH - 1);
    localparam logic [TX_BUF_WIDTH:0] TX_ONE_WORD = (TX_BUF_WIDTH+1)'(1);

    // Elaboration-time guard against unusable parameter sets.
    generate
        if ((DATA_WIDTH % 8) != 0 || MAX_BURST < 1) begin : g_param_check
            $error("ft60x_mode245_bridge: DATA_WIDTH must be a multiple of 8 and MAX_BURST >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        RX_OE,
        RX_READ,
        TX_WRITE,
        TURN
    } state_t;

    state_t state_q;

    logic                  ft_oe_q, ft_rd_q, ft_wr_q, ft_bus_oe_q;
    logic [DATA_WIDTH-1:0] ft_data_out_q;
    logic [BE_W-1:0]       ft_be_out_q;

    // -----------------------------------------------------------------------
    // TX FIFO: extra pointer MSB distinguishes full from empty.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   tx_mem [TX_DEPTH];
    logic [TX_BUF_WIDTH:0]   tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TX_BUF_WIDTH:0]   tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_BUF_WIDTH:0]   tx_count;
    logic [TX_BUF_WIDTH-1:0] tx_rd_addr, tx_rd_addr_nxt;
    logic                    tx_empty_w, tx_full_w, tx_push, tx_pop;

    assign tx_count       = tx_wr_ptr_q - tx_rd_ptr_q;
    assign tx_empty_w     = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign tx_full_w      = (tx_wr_ptr_q[TX_BUF_WIDTH] != tx_rd_ptr_q[TX_BUF_WIDTH]) &&
                            (tx_wr_ptr_q[TX_BUF_WIDTH-1:0] == tx_rd_ptr_q[TX_BUF_WIDTH-1:0]);
    assign tx_rd_addr     = tx_rd_ptr_q[TX_BUF_WIDTH-1:0];
    assign tx_rd_addr_nxt = tx_rd_addr + TX_BUF_WIDTH'(1);
    assign tx_push        = tx_en && !tx_full_w;
    // The chip takes the word on the edge where our WR# is low and TXE# is low.
    assign tx_pop         = (state_q == TX_WRITE) && !ft_wr_q && !ft_txe && !tx_empty_w;

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + (TX_BUF_WIDTH+1)'(1);
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + (TX_BUF_WIDTH+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q[TX_BUF_WIDTH-1:0]] <= tx_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
        end
    end

    // -----------------------------------------------------------------------
    // RX FIFO: stores {byte enables, data} per word.
    // -----------------------------------------------------------------------
    logic [RX_W-1:0]         rx_mem [RX_DEPTH];
    logic [RX_BUF_WIDTH:0]   rx_wr_ptr_q, rx_wr_ptr_d;
    logic [RX_BUF_WIDTH:0]   rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_BUF_WIDTH:0]   rx_count;
    logic                    rx_empty_w, rx_full_w, rx_wr, rx_pop, rx_fills;

    assign rx_count   = rx_wr_ptr_q - rx_rd_ptr_q;
    assign rx_empty_w = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_full_w  = (rx_wr_ptr_q[RX_BUF_WIDTH] != rx_rd_ptr_q[RX_BUF_WIDTH]) &&
                        (rx_wr_ptr_q[RX_BUF_WIDTH-1:0] == rx_rd_ptr_q[RX_BUF_WIDTH-1:0]);
    assign rx_pop     = rx_en && !rx_empty_w;
    // The chip presents a valid word on every edge where RD# (ours) and RXF# are low.
    assign rx_wr      = (state_q == RX_READ) && !ft_rd_q && !ft_rxf && !rx_full_w;
    // This edge's write leaves no free slot, so RD# must rise at this same edge.
    assign rx_fills   = rx_wr && !rx_pop && (rx_count == RX_ONE_FREE);

    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        if (rx_wr)  rx_wr_ptr_d = rx_wr_ptr_q + (RX_BUF_WIDTH+1)'(1);
        if (rx_pop) rx_rd_ptr_d = rx_rd_ptr_q + (RX_BUF_WIDTH+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wr_ptr_q[RX_BUF_WIDTH-1:0]] <= {ft_be_in, ft_data_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
        end else begin
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
        end
    end

    assign {rx_be, rx_out} = rx_mem[rx_rd_ptr_q[RX_BUF_WIDTH-1:0]];
    assign rx_empty        = rx_empty_w;
    assign tx_full         = tx_full_w;

    // -----------------------------------------------------------------------
    // Burst limiting and direction fairness.
    // -----------------------------------------------------------------------
    logic burst_last;   // the word moved at this edge is the last of the burst
    logic favour_tx;    // IDLE should prefer TX when both directions are ready

`ifdef FT_BURST_LIMIT_EN
    localparam int BC_W = $clog2(MAX_BURST + 1);
    logic [BC_W-1:0] burst_cnt_q;
    logic            favour_tx_q;

    assign burst_last = (rx_wr || tx_pop) && (burst_cnt_q == BC_W'(MAX_BURST - 1));
    assign favour_tx  = favour_tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= '0;
            favour_tx_q <= 1'b0;
        end else begin
            if (state_q == IDLE)
                burst_cnt_q <= '0;
            else if (rx_wr || tx_pop)
                burst_cnt_q <= burst_cnt_q + BC_W'(1);
            // Remember the direction just served so the other gets the next turn.
            if (state_q == RX_READ)
                favour_tx_q <= 1'b1;
            else if (state_q == TX_WRITE)
                favour_tx_q <= 1'b0;
        end
    end
`else
    assign burst_last = 1'b0;
    assign favour_tx  = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Bus FSM with registered chip-side outputs.
    // -----------------------------------------------------------------------
    logic rx_ready, tx_ready;
    assign rx_ready = !ft_rxf && !rx_full_w;
    assign tx_ready = !ft_txe && !tx_empty_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ft_oe_q       <= 1'b1;
            ft_rd_q       <= 1'b1;
            ft_wr_q       <= 1'b1;
            ft_bus_oe_q   <= 1'b0;
            ft_data_out_q <= '0;
            ft_be_out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_ready && !(favour_tx && tx_ready)) begin
                        state_q <= RX_OE;
                        ft_oe_q <= 1'b0;
                        ft_rd_q <= 1'b1;
                    end else if (tx_ready) begin
                        state_q       <= TX_WRITE;
                        ft_bus_oe_q   <= 1'b1;
                        ft_wr_q       <= 1'b0;
                        ft_data_out_q <= tx_mem[tx_rd_addr];
                        ft_be_out_q   <= '1;
                    end
                end
                RX_OE: begin
                    state_q <= RX_READ;
                    ft_rd_q <= 1'b0;
                end
                RX_READ: begin
                    if (ft_rxf || rx_fills || burst_last) begin
                        state_q <= TURN;
                        ft_oe_q <= 1'b1;
                        ft_rd_q <= 1'b1;
                    end
                end
                TX_WRITE: begin
                    // TXE# high: the current word was not taken; leave it at
                    // the FIFO head for the next burst.
                    if (ft_txe || (tx_pop && (tx_count == TX_ONE_WORD || burst_last))) begin
                        state_q     <= TURN;
                        ft_wr_q     <= 1'b1;
                        ft_bus_oe_q <= 1'b0;
                        ft_be_out_q <= '0;
                    end else if (tx_pop) begin
                        // At least two words remain, so the next slot is valid.
                        ft_data_out_q <= tx_mem[tx_rd_addr_nxt];
                    end
                end
                TURN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ft_oe       = ft_oe_q;
    assign ft_rd       = ft_rd_q;
    assign ft_wr       = ft_wr_q;
    assign ft_bus_oe   = ft_bus_oe_q;
    assign ft_data_out = ft_data_out_q;
    assign ft_be_out   = ft_be_out_q;

endmodule

`default_nettype wire

// File: doc/ft60x_mode245_bridge.md
FT60X_MODE245_BRIDGE -- requirements
Module: ft60x_mode245_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning FT bus width (16 = FT600, 32 = FT601).
REQ-002 SHALL have parameter RX_BUF_WIDTH, default 4, meaning log2 of RX FIFO depth in words.
REQ-003 SHALL have parameter TX_BUF_WIDTH, default 4, meaning log2 of TX FIFO depth in words.
REQ-004 SHALL have parameter MAX_BURST, default 8, meaning words per burst before arbitration (used only under REQ-031).
REQ-005 SHALL have ports, in this order:
  clk  in  1  single clock, the FT chip clock; synchronous reset is active-high.
  rst  in  1  synchronous active-high reset.
  tx_en  in  1  push tx_in into TX FIFO.
  tx_in  in  DATA_WIDTH  TX word.
  tx_full  out  1  TX FIFO full.
  rx_en  in  1  pop RX FIFO head.
  rx_out  out  DATA_WIDTH  RX FIFO head (show-ahead).
  rx_be  out  DATA_WIDTH/8  byte enables stored with rx_out.
  rx_empty  out  1  RX FIFO empty.
  ft_data_in  in  DATA_WIDTH  FT data bus, input side.
  ft_data_out  out  DATA_WIDTH  FT data bus, output side.
  ft_be_in  in  DATA_WIDTH/8  FT byte enables, input side.
  ft_be_out  out  DATA_WIDTH/8  FT byte enables, output side.
  ft_bus_oe  out  1  high = bridge drives ft_data/ft_be pads.
  ft_txe  in  1  active-low, chip can accept a word.
  ft_rxf  in  1  active-low, chip has a word.
  ft_oe  out  1  active-low chip output enable.
  ft_rd  out  1  active-low read strobe.
  ft_wr  out  1  active-low write strobe.

Function
REQ-010 All FT outputs SHALL be registered on clk.
REQ-011 FSM states SHALL be IDLE, RX_OE, RX_READ, TX_WRITE, TURN.
REQ-012 IDLE: if ft_rxf low and RX FIFO not full -> RX_OE; else if ft_txe low and TX FIFO not empty -> TX_WRITE; else stay. RX has priority.
REQ-013 RX_OE: ft_oe low, ft_rd high, ft_bus_oe low; one cycle, then -> RX_READ.
REQ-014 RX_READ: ft_oe and ft_rd low; at each edge with registered ft_rd low and ft_rxf low, {ft_be_in, ft_data_in} SHALL be written to RX FIFO.
REQ-015 RX_READ SHALL exit to TURN at the edge where ft_rxf is high or where RX free slots after this edge's write would be 0; ft_oe/ft_rd go high at that same edge; RX FIFO SHALL never overflow.
REQ-016 TX_WRITE: ft_bus_oe high, ft_wr low, ft_data_out = TX head, ft_be_out all ones; word popped at each edge with registered ft_wr low and ft_txe low.
REQ-017 TX_WRITE SHALL hold the same word while ft_txe high, and exit to TURN when ft_txe high or TX FIFO becomes empty; no word dropped or duplicated.
REQ-018 TURN: all strobes high, ft_bus_oe low, exactly one cycle, -> IDLE.
REQ-019 ft_bus_oe and ft_oe low SHALL never be asserted in the same cycle.
REQ-020 Both FIFOs SHALL be synchronous, show-ahead; push when full and pop when empty SHALL be ignored; simultaneous push/pop on a non-empty non-full FIFO keeps count.
REQ-021 Pointers SHALL wrap modulo 2^BUF_WIDTH; full/empty SHALL use one extra pointer bit.
REQ-022 tx_full and rx_empty SHALL update the cycle after the causing push/pop.

Reset
REQ-030 While rst high at an edge: state IDLE, FIFOs empty, ft_oe/ft_rd/ft_wr high, ft_bus_oe low, ft_data_out 0, ft_be_out 0, tx_full 0, rx_empty 1; reset mid-burst SHALL abort the burst and discard FIFO contents.

Configuration
REQ-031 Macro FT_BURST_LIMIT_EN defined: a burst SHALL end (-> TURN) after MAX_BURST transferred words, and the next IDLE decision SHALL favour the opposite direction if it is ready.
REQ-032 FT_BURST_LIMIT_EN undefined: bursts are unbounded and RX always has priority; MAX_BURST is unused.

Verification
REQ-040 rxf low, data 0x0123 then 0x4567, rx_en high: oe low one cycle before rd; FIFO receives 0x0123, 0x4567 in order; rx_be = 2'b11.
REQ-041 rxf held low, rx_en low, RX_BUF_WIDTH 4: exactly 16 words stored, rd high, no overflow, rx_empty 0.
REQ-042 push 0xA000..0xA004, txe low, stall txe high one cycle mid-burst: chip sees 5 words in order, none duplicated, wr high after last.
REQ-043 rxf and txe both low, both FIFOs ready, FT_BURST_LIMIT_EN with MAX_BURST 4: 4 reads, TURN, 4 writes, alternating; without macro: reads continue until rxf high.
REQ-044 rst asserted mid RX_READ: next cycle oe/rd high, rx_empty 1, state IDLE.
REQ-045 every cycle of all tests: never ft_bus_oe high with ft_oe low; TURN precedes each direction change.
